// File: rtl/switch_bus_reader_pkg.sv
// Shared constants for the switch/button bus reader.
//   Register offsets from the base address, change-flag bit positions inside
//   the flags register, and interrupt-enable bit positions inside the IE
//   register.
package switch_bus_reader_pkg;

  localparam int NumSw  = 8;
  localparam int NumBtn = 4;

  // Register offsets (address - BaseAddr)
  localparam logic [1:0] OffsSw    = 2'd0;
  localparam logic [1:0] OffsBtn   = 2'd1;
  localparam logic [1:0] OffsFlags = 2'd2;
  localparam logic [1:0] OffsIe    = 2'd3;

  // Flags register: btnChg occupies [3:0], swChg sits above it
  localparam int FlagBtnLo = 0;
  localparam int FlagSwChg = 4;

  // IE register bits
  localparam int IeSw  = 0;
  localparam int IeBtn = 1;

endpackage

// File: rtl/switch_bus_reader_debounce_filter.sv
// debounce_filter: 2-FF synchroniser plus a single shared stability counter
// for a vector of raw asynchronous inputs.
//   i_clk, i_rst   : clock, synchronous active-high reset
//   i_raw          : raw asynchronous inputs
//   o_state        : debounced vector
//   o_commit       : one-cycle strobe, o_state updates at the end of this cycle
//   o_toggled      : bits that change on this commit (valid with o_commit)
module debounce_filter #(
  parameter int Width       = 12,
  parameter int DebounceMax = 999999,
  parameter int CtrWidth    = 20
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [Width-1:0] i_raw,
  output logic [Width-1:0] o_state,
  output logic             o_commit,
  output logic [Width-1:0] o_toggled
);

  localparam logic [CtrWidth-1:0] CntMax = CtrWidth'(DebounceMax);

  logic [Width-1:0]    r_sync1, r_sync2, r_prev, r_state;
  logic [CtrWidth-1:0] r_cnt;
  logic                w_stable;
  logic                w_commit;

  assign w_stable = (r_sync2 == r_prev);
  // The sample must also equal the previous one this cycle, so a change
  // arriving just as the counter saturates is not committed early.
  assign w_commit = (r_cnt == CntMax) && w_stable && (r_sync2 != r_state);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
      r_state <= '0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      if (!w_stable)
        r_cnt <= '0;
      else if (r_cnt != CntMax)
        r_cnt <= r_cnt + 1'b1;
      if (w_commit)
        r_state <= r_sync2;
    end
  end

  assign o_state   = r_state;
  assign o_commit  = w_commit;
  assign o_toggled = r_sync2 ^ r_state;

endmodule

// File: rtl/switch_bus_reader.sv
// switch_bus_reader: read-side bus peripheral for 8 slide switches and
// 4 push buttons.
//   CLK, RESET            : clock, synchronous active-high reset
//   BUS_DATA              : shared tristate data bus, driven only in the
//                           cycle after a valid read
//   BUS_ADDR, BUS_WE      : bus address / write strobe
//   BUS_INTERRUPT_RAISE   : interrupt request (registered pending flag)
//   BUS_INTERRUPT_ACK     : interrupt acknowledge
//   SWITCHES, BUTTONS     : raw asynchronous board inputs
// Registers at BaseAddr+0..3: switches, buttons, change flags (W1C), IE.
module switch_bus_reader
  import switch_bus_reader_pkg::*;
#(
  parameter logic [7:0] BaseAddr    = 8'hE0,
  parameter int         DebounceMax = 999999,
  parameter int         CtrWidth    = 20
) (
  input  logic       CLK,
  input  logic       RESET,
  inout  wire  [7:0] BUS_DATA,
  input  logic [7:0] BUS_ADDR,
  input  logic       BUS_WE,
  output logic       BUS_INTERRUPT_RAISE,
  input  logic       BUS_INTERRUPT_ACK,
  input  logic [7:0] SWITCHES,
  input  logic [3:0] BUTTONS
);

  logic [11:0] w_db, w_tog;
  logic        w_commit;

  debounce_filter #(
    .Width      (NumSw + NumBtn),
    .DebounceMax(DebounceMax),
    .CtrWidth   (CtrWidth)
  ) u_debounce (
    .i_clk    (CLK),
    .i_rst    (RESET),
    .i_raw    ({BUTTONS, SWITCHES}),
    .o_state  (w_db),
    .o_commit (w_commit),
    .o_toggled(w_tog)
  );

  // Flags kept as a full byte so the W1C mask uses the whole bus word;
  // bits 7:5 are never set and stay zero.
  logic [7:0] r_flags;
  logic [1:0] r_ie;
  logic       r_pending;
  logic       r_rd_en;
  logic [7:0] r_rd_data;

  logic [7:0] w_offs;
  logic       w_hit, w_rd, w_wr;
  logic       w_sw_tog;
  logic [3:0] w_btn_tog;
  logic [7:0] w_flag_set, w_flag_clr;
  logic       w_irq_set;
  logic [7:0] w_rd_mux;

  assign w_offs = BUS_ADDR - BaseAddr;
  assign w_hit  = (w_offs[7:2] == 6'd0);
  assign w_rd   = w_hit && !BUS_WE;
  assign w_wr   = w_hit && BUS_WE;

  assign w_sw_tog   = w_commit && (|w_tog[NumSw-1:0]);
  assign w_btn_tog  = w_commit ? w_tog[NumSw +: NumBtn] : 4'd0;
  assign w_flag_set = {3'b000, w_sw_tog, w_btn_tog};
  assign w_flag_clr = (w_wr && w_offs[1:0] == OffsFlags) ? BUS_DATA : 8'h00;
  assign w_irq_set  = (r_ie[IeSw] && w_sw_tog) || (r_ie[IeBtn] && (|w_btn_tog));

  // Read mux sees pre-commit register values, so a read coincident with a
  // commit returns the old state.
  always_comb begin
    w_rd_mux = 8'h00;
    case (w_offs[1:0])
      OffsSw:    w_rd_mux = w_db[NumSw-1:0];
      OffsBtn:   w_rd_mux = {4'b0000, w_db[NumSw +: NumBtn]};
      OffsFlags: w_rd_mux = r_flags;
      default:   w_rd_mux = {6'b000000, r_ie};
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_flags   <= 8'h00;
      r_ie      <= 2'b00;
      r_pending <= 1'b0;
      r_rd_en   <= 1'b0;
      r_rd_data <= 8'h00;
    end else begin
      // Set wins over a same-cycle W1C clear
      r_flags <= (r_flags & ~w_flag_clr) | w_flag_set;
      if (w_wr && w_offs[1:0] == OffsIe)
        r_ie <= BUS_DATA[1:0];
      // New enabled change wins over a same-cycle ACK
      if (w_irq_set)
        r_pending <= 1'b1;
      else if (BUS_INTERRUPT_ACK)
        r_pending <= 1'b0;
      r_rd_en   <= w_rd;
      r_rd_data <= w_rd_mux;
    end
  end

  assign BUS_INTERRUPT_RAISE = r_pending;
  assign BUS_DATA = r_rd_en ? r_rd_data : 8'bzzzz_zzzz;

endmodule

// File: tb/tb_switch_bus_reader.sv
// Testbench for switch_bus_reader with DebounceMax=15. The bus carries
// pull-ups, so an undriven (high-Z) bus reads back as 8'hFF.
module tb_switch_bus_reader;

  localparam logic [7:0] HIZ = 8'hFF;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [7:0] BUS_ADDR;
  logic       BUS_WE;
  logic       raise;
  logic       ack;
  logic [7:0] sw;
  logic [3:0] btn;
  wire  [7:0] BUS_DATA;
  logic [7:0] tb_d;
  logic       tb_oe;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  assign BUS_DATA = tb_oe ? tb_d : 8'bzzzz_zzzz;

  for (genvar i = 0; i < 8; i++) begin : g_pu
    pullup pu (BUS_DATA[i]);
  end

  switch_bus_reader #(
    .BaseAddr   (8'hE0),
    .DebounceMax(15),
    .CtrWidth   (4)
  ) dut (
    .CLK                (CLK),
    .RESET              (RESET),
    .BUS_DATA           (BUS_DATA),
    .BUS_ADDR           (BUS_ADDR),
    .BUS_WE             (BUS_WE),
    .BUS_INTERRUPT_RAISE(raise),
    .BUS_INTERRUPT_ACK  (ack),
    .SWITCHES           (sw),
    .BUTTONS            (btn)
  );

  typedef struct {
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp;
    string      name;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) step();
  endtask

  // Present a read for one cycle, check the response in the following cycle
  task automatic rd(input logic [7:0] a, input logic [7:0] exp, input string nm);
    step();
    BUS_ADDR = a;
    BUS_WE   = 1'b0;
    step();
    BUS_ADDR = 8'h00;
    @(negedge CLK);
    chk(nm, BUS_DATA, exp);
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    step();
    BUS_ADDR = a;
    BUS_WE   = 1'b1;
    tb_d     = d;
    tb_oe    = 1'b1;
    step();
    BUS_WE   = 1'b0;
    tb_oe    = 1'b0;
    BUS_ADDR = 8'h00;
  endtask

  task automatic add(input logic we, input logic [7:0] a, input logic [7:0] d,
                     input logic [7:0] e, input string nm);
    vq.push_back('{we, a, d, e, nm});
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    RESET = 1'b1; BUS_ADDR = 8'h00; BUS_WE = 1'b0; ack = 1'b0;
    sw = 8'h00; btn = 4'h0; tb_d = 8'h00; tb_oe = 1'b0;

    // Register-access table, applied right after reset (inputs all zero)
    add(0, 8'hE0, 8'h00, 8'h00, "rst_sw");
    add(0, 8'hE1, 8'h00, 8'h00, "rst_btn");
    add(0, 8'hE2, 8'h00, 8'h00, "rst_flags");
    add(0, 8'hE3, 8'h00, 8'h00, "rst_ie");
    add(1, 8'hE3, 8'hFF, HIZ,   "wr_ie_hiz");
    add(0, 8'hE3, 8'h00, 8'h03, "ie_mask");
    add(1, 8'hE0, 8'hFF, HIZ,   "wr_sw_hiz");
    add(0, 8'hE0, 8'h00, 8'h00, "ro_sw");
    add(1, 8'hE1, 8'hFF, HIZ,   "wr_btn_hiz");
    add(0, 8'hE1, 8'h00, 8'h00, "ro_btn");
    add(1, 8'hE2, 8'hFF, HIZ,   "wr_flags_hiz");
    add(0, 8'hE2, 8'h00, 8'h00, "w1c_empty");
    add(0, 8'hE4, 8'h00, HIZ,   "oor_E4");
    add(0, 8'hDF, 8'h00, HIZ,   "oor_DF");
    add(1, 8'hE3, 8'h00, HIZ,   "wr_ie0_hiz");
    add(0, 8'hE3, 8'h00, 8'h00, "ie_clear");

    wait_cyc(3);
    RESET = 1'b0;
    @(negedge CLK);
    chk("rst_raise", {7'd0, raise}, 8'h00);
    chk("rst_bus", BUS_DATA, HIZ);

    // Detailed read timing: high-Z in N, data in N+1, high-Z in N+2
    step();
    BUS_ADDR = 8'hE0;
    @(negedge CLK);
    chk("rd_cycN_hiz", BUS_DATA, HIZ);
    step();
    BUS_ADDR = 8'h00;
    @(negedge CLK);
    chk("rd_cycN1_data", BUS_DATA, 8'h00);
    step();
    @(negedge CLK);
    chk("rd_cycN2_hiz", BUS_DATA, HIZ);

    foreach (vq[i]) begin
      if (vq[i].we) begin
        wr(vq[i].addr, vq[i].wdata);
        @(negedge CLK);
        chk(vq[i].name, BUS_DATA, vq[i].exp);
      end else begin
        rd(vq[i].addr, vq[i].exp, vq[i].name);
      end
    end
    chk("tbl_raise", {7'd0, raise}, 8'h00);

    // Switch change: not committed yet after ~12 cycles, committed after ~24
    step();
    sw = 8'hA5;
    wait_cyc(10);
    rd(8'hE0, 8'h00, "sw_early");
    wait_cyc(10);
    rd(8'hE0, 8'hA5, "sw_commit");
    rd(8'hE2, 8'h10, "sw_flag");
    chk("sw_noirq", {7'd0, raise}, 8'h00);

    // Back-to-back reads drive continuously
    step();
    BUS_ADDR = 8'hE0;
    step();
    BUS_ADDR = 8'hE1;
    @(negedge CLK);
    chk("b2b_first", BUS_DATA, 8'hA5);
    step();
    BUS_ADDR = 8'h00;
    @(negedge CLK);
    chk("b2b_second", BUS_DATA, 8'h00);
    step();
    @(negedge CLK);
    chk("b2b_end_hiz", BUS_DATA, HIZ);

    // Button interrupt with ieBtn
    wr(8'hE2, 8'h10);
    rd(8'hE2, 8'h00, "w1c_sw");
    wr(8'hE3, 8'h02);
    step();
    btn = 4'b0100;
    wait_cyc(24);
    @(negedge CLK);
    chk("btn_irq", {7'd0, raise}, 8'h01);
    rd(8'hE2, 8'h04, "btn_flag");
    rd(8'hE1, 8'h04, "btn_state");
    step();
    ack = 1'b1;
    step();
    ack = 1'b0;
    @(negedge CLK);
    chk("ack_clear", {7'd0, raise}, 8'h00);
    wr(8'hE2, 8'h04);
    rd(8'hE2, 8'h00, "w1c_btn");

    // Short glitch back to the committed value: nothing happens
    step();
    btn = 4'b0101;
    wait_cyc(10);
    btn = 4'b0100;
    wait_cyc(24);
    rd(8'hE1, 8'h04, "glitch_state");
    rd(8'hE2, 8'h00, "glitch_flag");
    chk("glitch_noirq", {7'd0, raise}, 8'h00);

    // Release button -> pending; disabling IE keeps it
    step();
    btn = 4'b0000;
    wait_cyc(24);
    @(negedge CLK);
    chk("rel_irq", {7'd0, raise}, 8'h01);
    wr(8'hE3, 8'h00);
    @(negedge CLK);
    chk("ie_off_keeps", {7'd0, raise}, 8'h01);
    wr(8'hE3, 8'h02);

    // ACK and W1C of btnChg[2] land exactly on the commit cycle; set wins.
    // Raw change after edge 0 commits at edge DebounceMax+4 = 19.
    step();
    btn = 4'b0100;
    repeat (18) @(posedge CLK);
    #1;
    ack      = 1'b1;
    BUS_ADDR = 8'hE2;
    BUS_WE   = 1'b1;
    tb_d     = 8'h04;
    tb_oe    = 1'b1;
    step();
    ack      = 1'b0;
    BUS_WE   = 1'b0;
    tb_oe    = 1'b0;
    BUS_ADDR = 8'h00;
    @(negedge CLK);
    chk("ack_vs_set", {7'd0, raise}, 8'h01);
    rd(8'hE2, 8'h04, "w1c_vs_set");
    rd(8'hE1, 8'h04, "coinc_state");
    step();
    ack = 1'b1;
    step();
    ack = 1'b0;
    @(negedge CLK);
    chk("ack_clear2", {7'd0, raise}, 8'h00);

    // Reset mid-debounce, with a read in flight
    step();
    sw = 8'h3C;
    wait_cyc(10);
    RESET    = 1'b1;
    BUS_ADDR = 8'hE0;
    BUS_WE   = 1'b0;
    step();
    BUS_ADDR = 8'h00;
    @(negedge CLK);
    chk("rst_rd_cancel", BUS_DATA, HIZ);
    chk("rst2_raise", {7'd0, raise}, 8'h00);
    step();
    RESET = 1'b0;
    rd(8'hE0, 8'h00, "rst2_sw");
    rd(8'hE1, 8'h00, "rst2_btn");
    rd(8'hE2, 8'h00, "rst2_flags");
    rd(8'hE3, 8'h00, "rst2_ie");
    wait_cyc(4);
    rd(8'hE0, 8'h00, "rst2_discard");
    wait_cyc(10);
    rd(8'hE0, 8'h3C, "rst2_recommit_sw");
    rd(8'hE1, 8'h04, "rst2_recommit_btn");
    rd(8'hE2, 8'h14, "rst2_flags_set");
    chk("rst2_noirq", {7'd0, raise}, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
